// File: rtl/timing_multi.sv
// Multi-channel pulse-to-feedback interval timer: each channel counts clock edges
// from a qualified start pulse to a feedback catch, or to a fixed timeout.
//   state   | meaning
//   IDLE    | waiting for a qualified start; result and timeout flag held
//   BUSY    | counting edges until catch, timeout, restart, disable or clear
module timing_multi #(
  parameter int                CH      = 4,
  parameter int                WIDTH   = 32,
  parameter logic [WIDTH-1:0]  TIMEOUT = {WIDTH{1'b1}}
) (
  input  logic                  io_clk,
  input  logic                  io_rst_n,
  input  logic                  io_clear,
  input  logic [CH-1:0]         io_enable,
  input  logic [CH-1:0]         io_defaultLevel_Pulse,
  input  logic [CH-1:0]         io_pulsePort,
  input  logic [CH-1:0]         io_fbCatch,
  output logic [CH*WIDTH-1:0]   io_timing,
  output logic [CH-1:0]         io_valid,
  output logic [CH-1:0]         io_timeout,
  output logic [CH-1:0]         io_busy
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  for (genvar n = 0; n < CH; n++) begin : g_ch
    logic             w_act;
    logic             w_start;
    logic             r_act_d;
    logic             r_act_d1;
    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_valid;
    logic             r_timeout;

    assign w_act   = io_pulsePort[n] ^ io_defaultLevel_Pulse[n];
    assign w_start = w_act & r_act_d & ~r_act_d1;

    // History is kept already XORed with the idle level so reset can force it inactive.
    always_ff @(posedge io_clk or negedge io_rst_n) begin
      if (!io_rst_n) begin
        r_act_d  <= 1'b0;
        r_act_d1 <= 1'b0;
      end else begin
        r_act_d  <= w_act;
        r_act_d1 <= r_act_d;
      end
    end

    always_ff @(posedge io_clk or negedge io_rst_n) begin
      if (!io_rst_n) begin
        r_state   <= ST_IDLE;
        r_cnt     <= '0;
        r_result  <= '0;
        r_valid   <= 1'b0;
        r_timeout <= 1'b0;
      end else begin
        r_valid <= 1'b0;
        if (io_clear) begin
          r_state   <= ST_IDLE;
          r_cnt     <= '0;
          r_result  <= '0;
          r_timeout <= 1'b0;
        end else if (!io_enable[n]) begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end else if (w_start) begin
          r_state <= ST_BUSY;
          r_cnt   <= {{(WIDTH-1){1'b0}}, 1'b1};
        end else if (r_state == ST_BUSY) begin
          if (io_fbCatch[n]) begin
            r_result  <= r_cnt;
            r_timeout <= 1'b0;
            r_valid   <= 1'b1;
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
          end else if (r_cnt == TIMEOUT) begin
            r_result  <= TIMEOUT;
            r_timeout <= 1'b1;
            r_valid   <= 1'b1;
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end
    end

    assign io_timing[n*WIDTH +: WIDTH] = r_result;
    assign io_valid[n]                 = r_valid;
    assign io_timeout[n]               = r_timeout;
    assign io_busy[n]                  = (r_state == ST_BUSY);
  end

endmodule

// File: tb/tb_timing_multi.sv
// Directed bench for timing_multi: CH=4, WIDTH=8, TIMEOUT=12, channel 1 idles high.
module tb_timing_multi;
  localparam int CH = 4;
  localparam int W  = 8;

  logic              clk;
  logic              rst_n;
  logic              clear;
  logic [CH-1:0]     enable;
  logic [CH-1:0]     dlevel;
  logic [CH-1:0]     pulse;
  logic [CH-1:0]     fb;
  logic [CH*W-1:0]   timing;
  logic [CH-1:0]     valid;
  logic [CH-1:0]     tmo;
  logic [CH-1:0]     busy;

  int checks = 0;
  int errors = 0;

  timing_multi #(.CH(CH), .WIDTH(W), .TIMEOUT(8'd12)) dut (
    .io_clk                (clk),
    .io_rst_n              (rst_n),
    .io_clear              (clear),
    .io_enable             (enable),
    .io_defaultLevel_Pulse (dlevel),
    .io_pulsePort          (pulse),
    .io_fbCatch            (fb),
    .io_timing             (timing),
    .io_valid              (valid),
    .io_timeout            (tmo),
    .io_busy               (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    clear  = 1'b0;
    enable = 4'b1111;
    dlevel = 4'b0010;
    pulse  = 4'b0010;
    fb     = 4'b0000;
    #23;
    chk("rst_timing", timing, 32'h0);
    chk("rst_valid", {28'h0, valid}, 32'h0);
    chk("rst_timeout", {28'h0, tmo}, 32'h0);
    chk("rst_busy", {28'h0, busy}, 32'h0);
    rst_n = 1'b1;
    step(2);

    // basic measurement on ch0: start edge 0, catch edge 10
    pulse[0] = 1'b1;
    step(1);
    chk("c0_not_yet", {31'h0, busy[0]}, 32'h0);
    step(1);
    chk("c0_start", {31'h0, busy[0]}, 32'h1);
    step(9);
    chk("c0_no_early_valid", {28'h0, valid}, 32'h0);
    fb[0] = 1'b1;
    step(1);
    chk("c0_result", {24'h0, timing[7:0]}, 32'd10);
    chk("c0_valid", {28'h0, valid}, 32'h1);
    chk("c0_timeout", {28'h0, tmo}, 32'h0);
    chk("c0_busy_drop", {28'h0, busy}, 32'h0);
    chk("c0_others", {8'h0, timing[31:8]}, 32'h0);
    fb[0] = 1'b0;
    step(1);
    chk("c0_strobe_one", {28'h0, valid}, 32'h0);
    chk("c0_hold", {24'h0, timing[7:0]}, 32'd10);
    fb[0] = 1'b1;
    step(2);
    chk("idle_catch_valid", {28'h0, valid}, 32'h0);
    chk("idle_catch_hold", {24'h0, timing[7:0]}, 32'd10);
    fb[0] = 1'b0;
    pulse[0] = 1'b0;
    step(2);

    // ch1 idles high: single-sample glitch must not start
    pulse[1] = 1'b0;
    step(1);
    pulse[1] = 1'b1;
    step(1);
    chk("c1_glitch", {31'h0, busy[1]}, 32'h0);
    step(1);
    chk("c1_glitch2", {31'h0, busy[1]}, 32'h0);
    pulse[1] = 1'b0;
    step(1);
    chk("c1_one_sample", {31'h0, busy[1]}, 32'h0);
    step(1);
    chk("c1_start", {31'h0, busy[1]}, 32'h1);
    // no catch: timeout at edge 12
    step(11);
    chk("c1_pre_tmo_busy", {31'h0, busy[1]}, 32'h1);
    chk("c1_pre_tmo_valid", {31'h0, valid[1]}, 32'h0);
    step(1);
    chk("c1_tmo_valid", {28'h0, valid}, 32'h2);
    chk("c1_tmo_flag", {28'h0, tmo}, 32'h2);
    chk("c1_tmo_result", {24'h0, timing[15:8]}, 32'd12);
    chk("c1_tmo_busy", {31'h0, busy[1]}, 32'h0);
    step(1);
    chk("c1_tmo_strobe_one", {31'h0, valid[1]}, 32'h0);
    chk("c1_tmo_hold", {31'h0, tmo[1]}, 32'h1);

    // ch2: catch coincident with cnt == TIMEOUT
    pulse[2] = 1'b1;
    step(2);
    chk("c2_start", {31'h0, busy[2]}, 32'h1);
    step(11);
    fb[2] = 1'b1;
    step(1);
    chk("c2_coinc_result", {24'h0, timing[23:16]}, 32'd12);
    chk("c2_coinc_tmo", {31'h0, tmo[2]}, 32'h0);
    chk("c2_coinc_valid", {31'h0, valid[2]}, 32'h1);
    fb[2] = 1'b0;
    pulse[2] = 1'b0;

    // ch3: restart at cnt=7, catch 4 edges later
    pulse[3] = 1'b1;
    step(2);
    chk("c3_start", {31'h0, busy[3]}, 32'h1);
    step(4);
    pulse[3] = 1'b0;
    step(1);
    pulse[3] = 1'b1;
    step(2);
    chk("c3_restart_busy", {31'h0, busy[3]}, 32'h1);
    chk("c3_restart_nostrobe", {31'h0, valid[3]}, 32'h0);
    step(3);
    chk("c3_pre_catch", {31'h0, valid[3]}, 32'h0);
    fb[3] = 1'b1;
    step(1);
    chk("c3_restart_result", {24'h0, timing[31:24]}, 32'd4);
    chk("c3_restart_valid", {28'h0, valid}, 32'h8);
    fb[3] = 1'b0;
    step(1);
    chk("c3_strobe_one", {31'h0, valid[3]}, 32'h0);

    // all four channels, staggered starts, common catch
    pulse = 4'b0010;
    step(3);
    pulse[0] = 1'b1;
    step(1);
    pulse[1] = 1'b0;
    step(1);
    pulse[2] = 1'b1;
    step(1);
    pulse[3] = 1'b1;
    step(2);
    chk("all_busy", {28'h0, busy}, 32'hF);
    step(4);
    fb = 4'b1111;
    step(1);
    chk("all_results", timing, {8'd5, 8'd6, 8'd7, 8'd8});
    chk("all_valid", {28'h0, valid}, 32'hF);
    chk("all_tmo", {28'h0, tmo}, 32'h0);
    fb = 4'b0000;
    step(1);
    chk("all_valid_drop", {28'h0, valid}, 32'h0);

    // async reset mid-measurement
    pulse = 4'b0010;
    step(1);
    pulse[0] = 1'b1;
    step(2);
    chk("rst_pre_busy", {31'h0, busy[0]}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_timing", timing, 32'h0);
    chk("rst_async_busy", {28'h0, busy}, 32'h0);
    pulse[0] = 1'b0;
    #3;
    rst_n = 1'b1;
    step(3);
    chk("rst_after_busy", {28'h0, busy}, 32'h0);
    chk("rst_after_valid", {28'h0, valid}, 32'h0);

    // enable low mid-run holds prior result
    pulse[0] = 1'b1;
    step(2);
    step(2);
    fb[0] = 1'b1;
    step(1);
    chk("en_prior_result", {24'h0, timing[7:0]}, 32'd3);
    fb[0] = 1'b0;
    pulse[0] = 1'b0;
    step(1);
    pulse[0] = 1'b1;
    step(2);
    chk("en_run_busy", {31'h0, busy[0]}, 32'h1);
    enable = 4'b1110;
    step(1);
    chk("en_low_busy", {31'h0, busy[0]}, 32'h0);
    chk("en_low_valid", {31'h0, valid[0]}, 32'h0);
    chk("en_low_hold", {24'h0, timing[7:0]}, 32'd3);
    pulse[0] = 1'b0;
    step(1);
    pulse[0] = 1'b1;
    step(2);
    chk("en_low_start_ignored", {31'h0, busy[0]}, 32'h0);
    enable = 4'b1111;

    // synchronous clear
    pulse[2] = 1'b1;
    step(2);
    chk("clr_pre_busy", {31'h0, busy[2]}, 32'h1);
    clear = 1'b1;
    step(1);
    chk("clr_timing", timing, 32'h0);
    chk("clr_busy", {28'h0, busy}, 32'h0);
    chk("clr_valid", {28'h0, valid}, 32'h0);
    chk("clr_tmo", {28'h0, tmo}, 32'h0);
    clear = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/timing_multi.md
TIMING_MULTI -- requirements
Module: timing_multi

Interface
REQ-001 Parameter CH, default 4: number of independent measurement channels, 1..16.
REQ-002 Parameter WIDTH, default 32: counter and result width per channel, 8..32.
REQ-003 Parameter TIMEOUT, default 2**WIDTH-1: per-channel measurement limit in cycles, 2..2**WIDTH-1.
REQ-004 io_clk  in  1  sole clock, rising edge.
REQ-005 io_rst_n  in  1  asynchronous active-low reset.
REQ-006 io_clear  in  1  synchronous clear of all channels.
REQ-007 io_enable  in  CH  per-channel enable.
REQ-008 io_defaultLevel_Pulse  in  CH  per-channel idle level of io_pulsePort.
REQ-009 io_pulsePort  in  CH  per-channel start pulse, already synchronous to io_clk.
REQ-010 io_fbCatch  in  CH  per-channel feedback stop, level-sampled.
REQ-011 io_timing  out  CH*WIDTH  latched results; channel n occupies bits [n*WIDTH +: WIDTH].
REQ-012 io_valid  out  CH  one-cycle strobe per channel, high when a new result is present.
REQ-013 io_timeout  out  CH  per channel; 1 when the latched result ended by timeout.
REQ-014 io_busy  out  CH  per channel; 1 while measuring.

Function
REQ-015 Each channel SHALL be fully independent; all rules below apply per channel n.
REQ-016 active(x) = x XOR io_defaultLevel_Pulse[n]; pulse history registers p_d and p_d1 SHALL sample io_pulsePort[n] every cycle regardless of state or enable.
REQ-017 Qualified start = active(io_pulsePort) AND active(p_d) AND NOT active(p_d1), i.e. an active level held for two consecutive samples after an inactive one.
REQ-018 States: IDLE, BUSY; io_busy[n] = (state == BUSY).
REQ-019 Edge priority: clear > enable low > qualified start > fbCatch > timeout > increment.
REQ-020 Qualified start (IDLE or BUSY): cnt <= 1, state <= BUSY, no valid strobe; a start in BUSY silently restarts the measurement.
REQ-021 BUSY, io_fbCatch[n]=1, no start: result <= cnt, io_timeout[n] <= 0, io_valid[n] <= 1 for one cycle, state <= IDLE, cnt <= 0.
REQ-022 BUSY, no catch, cnt == TIMEOUT: result <= TIMEOUT, io_timeout[n] <= 1, io_valid[n] <= 1 for one cycle, state <= IDLE, cnt <= 0.
REQ-023 Catch and timeout on the same edge: catch wins, io_timeout[n] = 0, result = TIMEOUT.
REQ-024 BUSY otherwise: cnt <= cnt + 1; cnt SHALL never exceed TIMEOUT and never wrap.
REQ-025 Result = number of rising edges from the start edge to the catch edge (start at edge 0, catch sampled at edge 3 gives 3); valid latency is the catch edge itself, strobe visible the following cycle.
REQ-026 io_fbCatch[n] in IDLE SHALL be ignored; no strobe, result held.
REQ-027 io_enable[n]=0: state <= IDLE, cnt <= 0, no strobe; result and io_timeout[n] held; qualified starts ignored.
REQ-028 io_clear=1: all channels IDLE, cnt 0, results 0, io_timeout 0, io_valid 0; pulse history still updates.
REQ-029 Result and io_timeout[n] SHALL remain stable between strobes.

Reset
REQ-030 io_rst_n=0 SHALL asynchronously force all states IDLE, cnt 0, results 0, io_valid 0, io_timeout 0, io_busy 0, p_d and p_d1 to io_defaultLevel_Pulse-equivalent inactive (0 after XOR), independent of io_clk.
REQ-031 Reset mid-measurement SHALL discard the measurement with no strobe; release SHALL be synchronous in effect, and a start requires a fresh inactive-to-active transition after release.

Verification
REQ-032 CH=4, default level 0, ch0 pulse rises, start at edge 0, fbCatch[0] at edge 10 -> io_timing[31:0]=10, io_valid[0] one cycle, io_timeout[0]=0, other channels unchanged.
REQ-033 Default level 1 on ch1, pulse falls for one sample only -> no start; held two samples -> start, io_busy[1]=1.
REQ-034 TIMEOUT=5, no catch -> result 5, io_timeout=1, io_valid one cycle, io_busy drops same edge; catch coincident with cnt==5 -> result 5, io_timeout=0.
REQ-035 Restart: second qualified start at cnt=7, catch 4 edges later -> result 4, exactly one strobe.
REQ-036 All four channels started on different cycles, caught simultaneously -> four correct independent results, io_valid=4'b1111 in one cycle.
REQ-037 io_rst_n asserted between edges during BUSY -> all outputs 0 immediately; io_enable low mid-run -> io_busy 0, prior result held, no strobe; io_clear -> results 0.
